// File: rtl/change_dispenser.sv
// Greedy coin payout ($5/$2/$1), one registered eject pulse at a time.
// Optional TUBE_LIMIT_EN: finite per-denomination tubes with refill and short reporting.
module change_dispenser #(
  parameter int WIDTH        = 8,
  parameter int PULSE_CYCLES = 4,
  parameter int GAP_CYCLES   = 4,
  parameter int TUBE_INIT    = 10
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] amount,
  input  logic             refill,
  output logic             busy,
  output logic             done,
  output logic             coin5_out,
  output logic             coin2_out,
  output logic             coin1_out,
  output logic [WIDTH-1:0] remaining,
  output logic             short_flag,
  output logic [2:0]       tube_empty
);

  localparam int CMAX = (PULSE_CYCLES > GAP_CYCLES) ? PULSE_CYCLES : GAP_CYCLES;
  localparam int CW   = $clog2(CMAX + 1);
  localparam logic [CW-1:0] PULSE_LAST = CW'(PULSE_CYCLES - 1);
  localparam logic [CW-1:0] GAP_LAST   = CW'((GAP_CYCLES > 1) ? (GAP_CYCLES - 2) : 0);

  typedef enum logic [2:0] {IDLE, SELECT, PULSE, GAP, DONE} state_t;

  state_t           state, state_nxt;
  logic [CW-1:0]    cnt, cnt_nxt;
  logic [2:0]       coin_q, coin_nxt, pick;
  logic [WIDTH-1:0] rem_nxt, cval;
  logic             short_nxt;
  logic             ok5, ok2, ok1;

`ifdef TUBE_LIMIT_EN
  localparam int TW = $clog2(TUBE_INIT + 1);
  logic [TW-1:0] tube5, tube2, tube1;

  always_ff @(posedge clk) begin
    if (rst) begin
      tube5 <= TW'(TUBE_INIT);
      tube2 <= TW'(TUBE_INIT);
      tube1 <= TW'(TUBE_INIT);
    end else if (state == IDLE && refill) begin
      tube5 <= TW'(TUBE_INIT);
      tube2 <= TW'(TUBE_INIT);
      tube1 <= TW'(TUBE_INIT);
    end else if (state == SELECT) begin
      if (pick[2]) tube5 <= tube5 - TW'(1);
      if (pick[1]) tube2 <= tube2 - TW'(1);
      if (pick[0]) tube1 <= tube1 - TW'(1);
    end
  end

  assign ok5        = (tube5 != '0);
  assign ok2        = (tube2 != '0);
  assign ok1        = (tube1 != '0);
  assign tube_empty = {tube5 == '0, tube2 == '0, tube1 == '0};
`else
  localparam int unused_tube_init = TUBE_INIT;
  logic unused_refill;
  assign unused_refill = refill;
  assign ok5        = 1'b1;
  assign ok2        = 1'b1;
  assign ok1        = 1'b1;
  assign tube_empty = '0;
`endif

  // Largest eligible coin, one-hot {5,2,1}; zero when nothing can be paid.
  always_comb begin
    pick = '0;
    cval = '0;
    if (remaining >= WIDTH'(5) && ok5) begin
      pick = 3'b100;
      cval = WIDTH'(5);
    end else if (remaining >= WIDTH'(2) && ok2) begin
      pick = 3'b010;
      cval = WIDTH'(2);
    end else if (remaining != '0 && ok1) begin
      pick = 3'b001;
      cval = WIDTH'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // The SELECT cycle doubles as the final gap cycle, so GAP itself lasts
  // GAP_CYCLES-1 cycles and is skipped entirely when GAP_CYCLES is 1.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      IDLE:   if (start) state_nxt = SELECT;
      SELECT: begin
        cnt_nxt   = '0;
        state_nxt = (pick != '0) ? PULSE : DONE;
      end
      PULSE: begin
        if (cnt == PULSE_LAST) begin
          cnt_nxt   = '0;
          state_nxt = (GAP_CYCLES > 1) ? GAP : SELECT;
        end else begin
          cnt_nxt = cnt + CW'(1);
        end
      end
      GAP: begin
        if (cnt == GAP_LAST) begin
          cnt_nxt   = '0;
          state_nxt = SELECT;
        end else begin
          cnt_nxt = cnt + CW'(1);
        end
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    rem_nxt   = remaining;
    short_nxt = short_flag;
    coin_nxt  = '0;
    if (state == IDLE && start) begin
      rem_nxt   = amount;
      short_nxt = 1'b0;
    end
    if (state == SELECT) begin
      if (pick != '0)
        rem_nxt = remaining - cval;
      else if (remaining != '0)
        short_nxt = 1'b1;
    end
    if (state_nxt == PULSE)
      coin_nxt = (state == SELECT) ? pick : coin_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      coin_q     <= '0;
      remaining  <= '0;
      short_flag <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      coin_q     <= coin_nxt;
      remaining  <= rem_nxt;
      short_flag <= short_nxt;
      busy       <= (state_nxt != IDLE);
      done       <= (state_nxt == DONE);
    end
  end

  assign coin5_out = coin_q[2];
  assign coin2_out = coin_q[1];
  assign coin1_out = coin_q[0];

endmodule
